// File: rtl/part_vector_driver.sv
// Host-side driver for the part-tester serial protocol.
// Sends "P<hex>\r" apply-commands, parses "R<hex>\r" responses, tallies failures.
module part_vector_driver #(
    parameter int NPIS    = 14,
    parameter int NPOS    = 11,
    parameter int NVEC    = 16,
    parameter int AW      = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    output logic [AW-1:0]   vec_addr,
    input  logic [NPIS-1:0] vec_pi,
    input  logic [NPOS-1:0] vec_po_exp,
    output logic            tx_start_o,
    output logic [7:0]      tx_data_o,
    input  logic            tx_ready_i,
    input  logic [7:0]      rx_data_i,
    input  logic            new_rx_data_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW:0]     err_count,
    output logic [AW-1:0]   fail_addr,
    output logic            timeout_flag
);

    localparam int PD = (NPIS + 3) / 4;
    localparam int QD = (NPOS + 3) / 4;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(PD + 2);
    localparam int DW = $clog2(QD + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SEND, S_TXW, S_HUNT,
        S_RXD, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t          state;
    logic [PD*4-1:0] pi_r;
    logic [NPOS-1:0] exp_r;
    logic [QD*4-1:0] resp;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   dcnt;
    logic [TW-1:0]   tcnt;
    logic            hold;
    logic            counted;

    logic [4:0] hv;
    logic       tmo;
    logic       ferr;
    logic       mism;
    logic       fail_ev;

    // {valid, nibble} for an ASCII hex digit of either case
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, 4'(c[3:0] + 4'd9)};
        else
            return 5'd0;
    endfunction

    function automatic logic [7:0] nib_asc(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        hv   = hex_val(rx_data_i);
        tmo  = (state == S_HUNT || state == S_RXD) &&
               (tcnt == TW'(TIMEOUT - 1));
        ferr = 1'b0;
        if (state == S_RXD && new_rx_data_i) begin
            if (dcnt == DW'(QD))
                ferr = (rx_data_i != 8'h0D);
            else
                ferr = !hv[4];
        end
        mism    = (state == S_CHECK) && (resp[NPOS-1:0] != exp_r);
        fail_ev = tmo | ferr | mism;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            vec_addr     <= '0;
            tx_start_o   <= 1'b0;
            tx_data_o    <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_addr    <= '0;
            timeout_flag <= 1'b0;
            pi_r         <= '0;
            exp_r        <= '0;
            resp         <= '0;
            idx          <= '0;
            dcnt         <= '0;
            tcnt         <= '0;
            hold         <= 1'b0;
            counted      <= 1'b0;
        end else begin
            tx_start_o <= 1'b0;

            // a vector is charged at most once, even across retries
            if (fail_ev && !counted) begin
                counted <= 1'b1;
                if (~&err_count)
                    err_count <= err_count + 1'b1;
                if (err_count == '0)
                    fail_addr <= vec_addr;
            end

            if (state == S_HUNT || state == S_RXD)
                tcnt <= tcnt + 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count    <= '0;
                        fail_addr    <= '0;
                        timeout_flag <= 1'b0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        vec_addr     <= '0;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    counted <= 1'b0;
                    idx     <= '0;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (idx == '0) begin
                        tx_data_o <= 8'h50;
                        pi_r      <= (PD*4)'(vec_pi);
                        exp_r     <= vec_po_exp;
                    end else if (idx == IW'(PD + 1)) begin
                        tx_data_o <= 8'h0D;
                    end else begin
                        tx_data_o <= nib_asc(pi_r[PD*4-1 -: 4]);
                        pi_r      <= pi_r << 4;
                    end
                    hold  <= 1'b0;
                    state <= S_TXW;
                end
                S_TXW: begin
                    if (!hold) begin
                        if (tx_ready_i) begin
                            tx_start_o <= 1'b1;
                            if (idx == IW'(PD + 1)) begin
                                tcnt  <= '0;
                                state <= S_HUNT;
                            end else begin
                                hold <= 1'b1;
                            end
                        end
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_SEND;
                    end
                end
                S_HUNT: begin
                    if (tmo) begin
                        timeout_flag <= 1'b1;
                        state        <= S_NEXT;
                    end else if (new_rx_data_i && rx_data_i == 8'h52) begin
                        dcnt  <= '0;
                        resp  <= '0;
                        state <= S_RXD;
                    end
                end
                S_RXD: begin
                    if (tmo) begin
                        timeout_flag <= 1'b1;
                        state        <= S_NEXT;
                    end else if (ferr) begin
                        tcnt  <= '0;
                        state <= S_HUNT;
                    end else if (new_rx_data_i) begin
                        if (dcnt == DW'(QD)) begin
                            state <= S_CHECK;
                        end else begin
                            resp <= {resp[QD*4-5:0], hv[3:0]};
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                S_CHECK: state <= S_NEXT;
                S_NEXT: begin
                    if (vec_addr == AW'(NVEC - 1)) begin
                        state <= S_DONE;
                    end else begin
                        vec_addr <= vec_addr + 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
